// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard and stall controller for a 5-stage in-order core.
//
// Detects load-use and JALR-after-load hazards in ID and inserts bubbles into
// ID/EX. It freezes the whole pipeline while either cache has a miss pending,
// and flushes IF/ID on an ID-resolved taken branch or jump.
//
// FSM states:
//   RUN   - normal operation; hazards are evaluated every cycle.
//   STALL - issues the second bubble of a 2-cycle JALR stall (countdown driven).
//   WAIT  - cache freeze; remembers whether RUN or STALL was interrupted.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rs1, rs2, use_rs1, use_rs2  ID-stage source registers and their use flags
//   jalr, branch_taken          ID holds JALR / ID resolved a taken branch or jump
//   ID_EX_rd, ID_EX_memread     EX-stage destination and load flag
//   EX_MEM_rd, EX_MEM_memread   MEM-stage destination and load flag
//   icache_stall, dcache_stall  cache miss pending
//   PC_write, IF_ID_write       PC and IF/ID update enables
//   IF_ID_flush, ID_EX_bubble   turn IF/ID or ID/EX into a NOP
//   pipe_hold                   hold ID/EX, EX/MEM and MEM/WB
//   stall_cycles                count of cycles with PC_write low (saturating)
//
// Build option: define HAZARD_PERF_CNT_EN to build the stall_cycles counter;
// without it stall_cycles is tied to 0 and no counter register exists.

module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic        jalr,
  input  logic        branch_taken,
  input  logic [4:0]  ID_EX_rd,
  input  logic        ID_EX_memread,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_memread,
  input  logic        icache_stall,
  input  logic        dcache_stall,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        pipe_hold,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state;
  state_t     saved_state;
  state_t     eff_state;
  logic [1:0] countdown;

  logic cache_stall;
  logic load_use;
  logic jalr_ex;
  logic jalr_mem;
  logic need_bubble;

  assign cache_stall = icache_stall | dcache_stall;

  assign load_use = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                    ((use_rs1 && (ID_EX_rd == rs1)) ||
                     (use_rs2 && (ID_EX_rd == rs2)));

  // A load in EX feeding JALR's rs1 needs two bubbles; a load in MEM needs one.
  // The EX case wins when both match because it is the younger producer.
  assign jalr_ex  = jalr && (rs1 != 5'd0) && ID_EX_memread && (ID_EX_rd == rs1);
  assign jalr_mem = jalr && (rs1 != 5'd0) && !jalr_ex &&
                    EX_MEM_memread && (EX_MEM_rd == rs1);

  assign need_bubble = jalr_ex || jalr_mem || load_use;

  // In the first cycle after a freeze ends, behave as the interrupted state so
  // no idle cycle is inserted between the freeze and a pending bubble.
  assign eff_state = (state == WAIT) ? saved_state : state;

  // Outputs are combinational so a bubble lands in the detection cycle.
  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (rst_n) begin
      if (cache_stall) begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        pipe_hold   = 1'b1;
      end else if (eff_state == STALL || need_bubble) begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
      end else if (branch_taken) begin
        IF_ID_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      saved_state <= RUN;
      countdown   <= 2'd0;
    end else if (cache_stall) begin
      // Countdown is left untouched so the pending bubble survives the freeze.
      if (state != WAIT) begin
        saved_state <= state;
      end
      state <= WAIT;
    end else if (eff_state == STALL) begin
      countdown <= countdown - 2'd1;
      state     <= (countdown <= 2'd1) ? RUN : STALL;
    end else if (jalr_ex) begin
      // First bubble is issued now; one more comes from STALL.
      countdown <= 2'd1;
      state     <= STALL;
    end else begin
      state <= RUN;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 32'd0;
    end else if (!PC_write && (cnt_reg != 32'hFFFF_FFFF)) begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  assign stall_cycles = cnt_reg;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level model that tracks owed bubbles as a count.

module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2;
  logic        use_rs1, use_rs2, jalr, branch_taken;
  logic [4:0]  ID_EX_rd, EX_MEM_rd;
  logic        ID_EX_memread, EX_MEM_memread;
  logic        icache_stall, dcache_stall;
  logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold;
  logic [31:0] stall_cycles;

  // Output vector order: PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold
  logic [4:0] outs;
  assign outs = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold};

  localparam logic [4:0] RUN_O   = 5'b11000;
  localparam logic [4:0] FLUSH_O = 5'b11100;
  localparam logic [4:0] BUB_O   = 5'b00010;
  localparam logic [4:0] HOLD_O  = 5'b00001;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt;

  hazard_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1            (rs1),
    .rs2            (rs2),
    .use_rs1        (use_rs1),
    .use_rs2        (use_rs2),
    .jalr           (jalr),
    .branch_taken   (branch_taken),
    .ID_EX_rd       (ID_EX_rd),
    .ID_EX_memread  (ID_EX_memread),
    .EX_MEM_rd      (EX_MEM_rd),
    .EX_MEM_memread (EX_MEM_memread),
    .icache_stall   (icache_stall),
    .dcache_stall   (dcache_stall),
    .PC_write       (PC_write),
    .IF_ID_write    (IF_ID_write),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_bubble   (ID_EX_bubble),
    .pipe_hold      (pipe_hold),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0; jalr = 0; branch_taken = 0;
    ID_EX_rd = 0; ID_EX_memread = 0; EX_MEM_rd = 0; EX_MEM_memread = 0;
    icache_stall = 0; dcache_stall = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_jalr2();
    clear_inputs();
    jalr = 1; rs1 = 7; use_rs1 = 1; ID_EX_memread = 1; ID_EX_rd = 7;
  endtask

  task automatic test_reset();
    // Hazard and cache stall present while in reset must not leak to outputs.
    clear_inputs();
    ID_EX_memread = 1; ID_EX_rd = 5; rs2 = 5; use_rs2 = 1; icache_stall = 1;
    #3;
    checks++;
    if (outs !== RUN_O) begin
      errors++; $display("FAIL reset_outs: got %b expected %b", outs, RUN_O);
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cycles);
    end
    clear_inputs();
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    checks++;
    if (outs !== RUN_O) begin
      errors++; $display("FAIL idle_outs: got %b expected %b", outs, RUN_O);
    end
    $display("test_reset done");
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ID_EX_memread = 1; ID_EX_rd = 5; rs2 = 5; use_rs2 = 1;
    @(negedge clk);
    checks++;
    if (outs !== BUB_O) begin
      errors++; $display("FAIL load_use_bubble: got %b expected %b", outs, BUB_O);
    end
    tick();
    clear_inputs();
    use_rs2 = 1; rs2 = 5;
    @(negedge clk);
    checks++;
    if (outs !== RUN_O) begin
      errors++; $display("FAIL load_use_release: got %b expected %b", outs, RUN_O);
    end
    $display("test_load_use done");
    tick();
  endtask

  task automatic test_jalr();
    set_jalr2();
    @(negedge clk);
    checks++;
    if (outs !== BUB_O) begin
      errors++; $display("FAIL jalr2_bubble1: got %b expected %b", outs, BUB_O);
    end
    tick();
    // Load has advanced to MEM; second bubble must still come from STALL.
    clear_inputs();
    jalr = 1; rs1 = 7; use_rs1 = 1; EX_MEM_memread = 1; EX_MEM_rd = 7;
    @(negedge clk);
    checks++;
    if (outs !== BUB_O) begin
      errors++; $display("FAIL jalr2_bubble2: got %b expected %b", outs, BUB_O);
    end
    tick();
    clear_inputs();
    jalr = 1; rs1 = 7; use_rs1 = 1;
    @(negedge clk);
    checks++;
    if (outs !== RUN_O) begin
      errors++; $display("FAIL jalr2_release: got %b expected %b", outs, RUN_O);
    end
    tick();
    clear_inputs();
    jalr = 1; rs1 = 7; use_rs1 = 1; EX_MEM_memread = 1; EX_MEM_rd = 7;
    @(negedge clk);
    checks++;
    if (outs !== BUB_O) begin
      errors++; $display("FAIL jalr1_bubble: got %b expected %b", outs, BUB_O);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (outs !== RUN_O) begin
      errors++; $display("FAIL jalr1_release: got %b expected %b", outs, RUN_O);
    end
`ifdef HAZARD_PERF_CNT_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    checks++;
    if (stall_cycles !== exp_cnt) begin
      errors++; $display("FAIL stall_count: got %0d expected %0d", stall_cycles, exp_cnt);
    end
    $display("test_jalr done");
    tick();
  endtask

  task automatic test_freeze();
    set_jalr2();
    @(negedge clk);
    checks++;
    if (outs !== BUB_O) begin
      errors++; $display("FAIL freeze_bubble1: got %b expected %b", outs, BUB_O);
    end
    tick();
    clear_inputs();
    dcache_stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== HOLD_O) begin
        errors++; $display("FAIL freeze_hold%0d: got %b expected %b", i, outs, HOLD_O);
      end
      tick();
    end
    dcache_stall = 0;
    @(negedge clk);
    checks++;
    if (outs !== BUB_O) begin
      errors++; $display("FAIL freeze_bubble2: got %b expected %b", outs, BUB_O);
    end
    tick();
    @(negedge clk);
    checks++;
    if (outs !== RUN_O) begin
      errors++; $display("FAIL freeze_release: got %b expected %b", outs, RUN_O);
    end
    $display("test_freeze done");
    tick();
  endtask

  task automatic test_flush();
    clear_inputs();
    branch_taken = 1; ID_EX_memread = 1; ID_EX_rd = 3; rs1 = 3; use_rs1 = 1;
    @(negedge clk);
    checks++;
    if (outs !== BUB_O) begin
      errors++; $display("FAIL flush_vs_hazard: got %b expected %b", outs, BUB_O);
    end
    tick();
    clear_inputs();
    branch_taken = 1;
    @(negedge clk);
    checks++;
    if (outs !== FLUSH_O) begin
      errors++; $display("FAIL flush_alone: got %b expected %b", outs, FLUSH_O);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (outs !== RUN_O) begin
      errors++; $display("FAIL flush_one_cycle: got %b expected %b", outs, RUN_O);
    end
    $display("test_flush done");
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_jalr2();
    tick();
    #1;
    checks++;
    if (outs !== BUB_O) begin
      errors++; $display("FAIL mid_stall_bubble: got %b expected %b", outs, BUB_O);
    end
    rst_n = 0;
    #1;
    checks++;
    if (outs !== RUN_O) begin
      errors++; $display("FAIL mid_stall_reset_outs: got %b expected %b", outs, RUN_O);
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++; $display("FAIL mid_stall_reset_cnt: got %0d expected 0", stall_cycles);
    end
    clear_inputs();
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    checks++;
    if (outs !== RUN_O) begin
      errors++; $display("FAIL mid_stall_discard: got %b expected %b", outs, RUN_O);
    end
    $display("test_reset_mid_stall done");
    tick();
  endtask

  task automatic test_random();
    int unsigned pending;
    logic [31:0] model_cnt;
    logic [4:0]  exp_o;
    logic        lu, j2, j1;
    int          nbub;
    rst_n = 0;
    clear_inputs();
    #1 rst_n = 1;
    tick();
    pending   = 0;
    model_cnt = 0;
    nbub      = 0;
    for (int c = 0; c < 600; c++) begin
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      use_rs1 = 1'($urandom_range(0, 1));
      use_rs2 = 1'($urandom_range(0, 1));
      jalr = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      ID_EX_rd = 5'($urandom_range(0, 3));
      ID_EX_memread = ($urandom_range(0, 2) == 0);
      EX_MEM_rd = 5'($urandom_range(0, 3));
      EX_MEM_memread = ($urandom_range(0, 2) == 0);
      icache_stall = ($urandom_range(0, 9) == 0);
      dcache_stall = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      lu = ID_EX_memread && ID_EX_rd != 0 &&
           ((use_rs1 && ID_EX_rd == rs1) || (use_rs2 && ID_EX_rd == rs2));
      j2 = jalr && rs1 != 0 && ID_EX_memread && ID_EX_rd == rs1;
      j1 = jalr && rs1 != 0 && !j2 && EX_MEM_memread && EX_MEM_rd == rs1;
`ifdef HAZARD_PERF_CNT_EN
      exp_cnt = model_cnt;
`else
      exp_cnt = 32'd0;
`endif
      if (icache_stall || dcache_stall) begin
        exp_o = HOLD_O;
      end else if (pending > 0) begin
        exp_o = BUB_O;
        pending--;
      end else if (j2) begin
        exp_o = BUB_O;
        pending = 1;
      end else if (j1 || lu) begin
        exp_o = BUB_O;
      end else if (branch_taken) begin
        exp_o = FLUSH_O;
      end else begin
        exp_o = RUN_O;
      end
      checks++;
      if (outs !== exp_o) begin
        errors++; $display("FAIL rand_outs cycle %0d: got %b expected %b", c, outs, exp_o);
      end
      checks++;
      if (stall_cycles !== exp_cnt) begin
        errors++; $display("FAIL rand_cnt cycle %0d: got %0d expected %0d", c, stall_cycles, exp_cnt);
      end
      if (!exp_o[4] && model_cnt != 32'hFFFF_FFFF) model_cnt++;
      if (exp_o == BUB_O) nbub++;
      tick();
    end
    $display("test_random done: 600 cycles, %0d bubbles", nbub);
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    exp_cnt = 0;
    test_reset();
    test_load_use();
    test_jalr();
    test_freeze();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 The ID-stage inputs SHALL be: rs1  in  5  ID rs1; rs2  in  5  ID rs2; use_rs1  in  1  ID reads rs1; use_rs2  in  1  ID reads rs2; jalr  in  1  ID holds JALR; branch_taken  in  1  ID-resolved taken branch/jump.
REQ-003 The EX-stage inputs SHALL be: ID_EX_rd  in  5  EX destination; ID_EX_memread  in  1  EX holds load.
REQ-004 The MEM-stage inputs SHALL be: EX_MEM_rd  in  5  MEM destination; EX_MEM_memread  in  1  MEM holds load.
REQ-005 The cache-stall inputs SHALL be: icache_stall  in  1  I-cache miss pending; dcache_stall  in  1  D-cache miss pending.
REQ-006 The outputs SHALL be: PC_write  out  1  PC update enable; IF_ID_write  out  1  IF/ID enable; IF_ID_flush  out  1  IF/ID to NOP; ID_EX_bubble  out  1  ID/EX to NOP; pipe_hold  out  1  hold ID/EX, EX/MEM, MEM/WB; stall_cycles  out  32  perf counter.

Function
REQ-007 The FSM SHALL have three states: RUN, STALL (bubble-insertion countdown), WAIT (cache freeze).
REQ-008 A load-use hazard SHALL be ID_EX_memread && ID_EX_rd!=0 && ((use_rs1 && ID_EX_rd==rs1) || (use_rs2 && ID_EX_rd==rs2)).
REQ-009 A JALR hazard SHALL be jalr && rs1!=0 && ((ID_EX_memread && ID_EX_rd==rs1) -> need 2) or else ((EX_MEM_memread && EX_MEM_rd==rs1) -> need 1).
REQ-010 Priority SHALL be: cache stall > JALR hazard > load-use hazard > branch_taken.
REQ-011 A bubble cycle SHALL drive PC_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0, pipe_hold=0.
REQ-012 Bubble insertion SHALL be combinational in the detection cycle; the 2-cycle JALR case SHALL load a 2-bit countdown with 1, enter STALL, and issue the second bubble from STALL; STALL returns to RUN when the countdown reaches 0 and re-evaluates hazards in that RUN cycle.
REQ-013 Load-use and 1-cycle JALR hazards SHALL produce exactly one bubble and remain in RUN.
REQ-014 When icache_stall|dcache_stall, the outputs SHALL be PC_write=0, IF_ID_write=0, pipe_hold=1, ID_EX_bubble=0, IF_ID_flush=0, and the FSM SHALL enter WAIT, saving the STALL countdown unchanged.
REQ-015 WAIT SHALL return to the saved state (RUN or STALL) in the first cycle in which both cache stalls are low.
REQ-016 branch_taken with no higher-priority event SHALL assert IF_ID_flush=1 for exactly that cycle, with PC_write=1 and IF_ID_write=1.
REQ-017 branch_taken coincident with a hazard SHALL be ignored; ID re-presents it after the stall.
REQ-018 With no event, the outputs SHALL be PC_write=1, IF_ID_write=1, and all others 0.
REQ-019 stall_cycles SHALL increment by 1 in each cycle in which PC_write=0, saturating at 0xFFFFFFFF.

Reset
REQ-020 rst_n low SHALL immediately force state=RUN, countdown=0, saved state=RUN, stall_cycles=0.
REQ-021 While in reset, outputs SHALL be PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0, pipe_hold=0.
REQ-022 Reset asserted mid-STALL or mid-WAIT SHALL discard pending bubbles.

Configuration
REQ-023 With macro HAZARD_PERF_CNT_EN defined, stall_cycles SHALL behave per REQ-019; when undefined, no counter register SHALL exist and stall_cycles SHALL be constant 0.

Verification
REQ-024 Load-use: ID_EX_memread=1, ID_EX_rd=5, rs2=5, use_rs2=1 -> one cycle PC_write=0, ID_EX_bubble=1; next cycle (hazard cleared) PC_write=1.
REQ-025 JALR after load: jalr=1, rs1=7, ID_EX_memread=1, ID_EX_rd=7 -> two consecutive bubble cycles, then RUN; with EX_MEM_memread=1, EX_MEM_rd=7 instead -> one bubble.
REQ-026 Freeze mid-STALL: JALR 2-bubble case with dcache_stall=1 for 3 cycles after the first bubble -> 3 cycles pipe_hold=1, ID_EX_bubble=0, then exactly one more bubble.
REQ-027 Flush vs hazard: branch_taken=1 with load-use on rs1=3 -> bubble only, IF_ID_flush=0; branch_taken alone -> IF_ID_flush=1 for 1 cycle.
REQ-028 Reset and counter: rst_n low during STALL -> RUN outputs immediately, stall_cycles=0; with HAZARD_PERF_CNT_EN, after REQ-024 and REQ-025 sequences stall_cycles=4 (1+2+1).
